sprite_cmd_queue: RTL and testbench

SPRITE_CMD_QUEUE -- requirements
Module: sprite_cmd_queue

---
 rtl/vga_cmd_pkg.sv | 44 ++++
 rtl/cmd_fifo.sv | 73 +++++++
 rtl/sprite_cmd_queue.sv | 173 +++++++++++++++++
 tb/tb_sprite_cmd_queue.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_cmd_pkg.sv
// Shared definitions for the sprite command queue.
// Holds the command-word field positions, the action codes, the queue FSM
// state encoding and the bit positions of the status word, plus a helper
// that extracts the action field from a command word.
package vga_cmd_pkg;

  // Command word layout
  localparam int CMD_COMP_MSB  = 31;
  localparam int CMD_COMP_LSB  = 26;
  localparam int CMD_CHILD_MSB = 25;
  localparam int CMD_CHILD_LSB = 21;
  localparam int CMD_ACT_MSB   = 20;
  localparam int CMD_ACT_LSB   = 17;
  localparam int CMD_ATYPE_MSB = 16;
  localparam int CMD_ATYPE_LSB = 14;
  localparam int CMD_BUF_BIT   = 13;
  localparam int CMD_DATA_MSB  = 12;
  localparam int CMD_DATA_LSB  = 0;

  // Action codes
  localparam logic [3:0] ACTION_SWAP   = 4'hF;
  localparam logic [3:0] ACTION_UPDATE = 4'h1;
  localparam logic [3:0] ACTION_NOP    = 4'h0;

  // Status word layout
  localparam int STAT_FILL_MSB    = 6;
  localparam int STAT_OVF_BIT     = 8;
  localparam int STAT_SWAP_BIT    = 9;
  localparam int STAT_DROP_LSB    = 10;
  localparam int STAT_DROP_MSB    = 15;
  localparam int STAT_SWAPCNT_LSB = 16;
  localparam int STAT_SWAPCNT_MSB = 31;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ISSUE       = 2'd1,
    ST_WAIT_VBLANK = 2'd2
  } cmd_state_e;

  function automatic logic [3:0] cmd_action(input logic [31:0] word);
    return word[CMD_ACT_MSB:CMD_ACT_LSB];
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO with first-word-fall-through head.
// Ports: clk, reset (sync, active-high), push/wdata (enqueue), pop (dequeue),
//        rdata (current head, valid when !empty), full, empty, count (fill level).
// A push while full is accepted only if a pop happens in the same cycle.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [6:0]       count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [6:0]       count_q, count_d;
  logic             push_ok, pop_ok;

  assign full    = (count_q == 7'(DEPTH));
  assign empty   = (count_q == 7'd0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Next-state for pointers and fill level
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    count_d = count_q + 7'(push_ok) - 7'(pop_ok);
  end

  // Pointer and fill-level registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 7'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (!reset && push_ok) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

endmodule

// File: rtl/sprite_cmd_queue.sv
// Sprite command queue: buffers CPU command words and broadcasts them one per
// cycle on cmd_out, holding buffer-swap commands until vertical blanking.
// Ports: clk, reset (sync, active-high), avs_write/avs_writedata (enqueue),
//        avs_read/avs_readdata (registered status), vcount (current VGA line),
//        cmd_out (broadcast command, 32'h0 when idle).
// Optional feature: define CMD_QUEUE_STATS_EN to add swap/drop counters in
// status bits [31:16] and [15:10]; otherwise those bits read 0.
module sprite_cmd_queue
  import vga_cmd_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int VBLANK_LINE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic [9:0]  vcount,
  output logic [31:0] cmd_out
);

  localparam logic [9:0] VBLANK_V = 10'(VBLANK_LINE);

  cmd_state_e  state_q, state_d;
  logic [31:0] cmd_q, cmd_d;
  logic [31:0] readdata_q, readdata_d;
  logic        ovf_q, ovf_d;
  logic        swap_done_q, swap_done_d;
  logic        pop_s, drop_s, issue_swap_s, in_vblank_s;
  logic [31:0] fifo_head_s, status_s;
  logic [3:0]  head_act_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [6:0]  fifo_count_s;
  cmd_state_e  after_pop_s;

  cmd_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (avs_write),
    .wdata (avs_writedata),
    .pop   (pop_s),
    .rdata (fifo_head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  assign head_act_s  = cmd_action(fifo_head_s);
  assign in_vblank_s = (vcount >= VBLANK_V);
  // Only the last remaining word leaves the queue empty; a full queue always
  // has more than one word, so the raw write strobe is sufficient here.
  assign after_pop_s = (fifo_count_s == 7'd1 && !avs_write) ? ST_IDLE : ST_ISSUE;
  assign drop_s      = avs_write && fifo_full_s && !pop_s;

  // Dequeue decision, FSM next state and swap-per-frame tracking
  always_comb begin
    state_d      = state_q;
    cmd_d        = 32'h0;
    pop_s        = 1'b0;
    issue_swap_s = 1'b0;
    if (in_vblank_s) begin
      swap_done_d = swap_done_q;
    end else begin
      swap_done_d = 1'b0;
    end
    case (state_q)
      ST_IDLE, ST_ISSUE: begin
        if (fifo_empty_s) begin
          state_d = ST_IDLE;
        end else if (head_act_s == ACTION_SWAP) begin
          state_d = ST_WAIT_VBLANK;
        end else begin
          pop_s   = 1'b1;
          state_d = after_pop_s;
          // NOP words are consumed silently
          if (head_act_s == ACTION_NOP) begin
            cmd_d = 32'h0;
          end else begin
            cmd_d = fifo_head_s;
          end
        end
      end
      ST_WAIT_VBLANK: begin
        if (!fifo_empty_s && in_vblank_s && !swap_done_q) begin
          pop_s        = 1'b1;
          issue_swap_s = 1'b1;
          cmd_d        = fifo_head_s;
          swap_done_d  = 1'b1;
          state_d      = after_pop_s;
        end else begin
          state_d = ST_WAIT_VBLANK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

`ifdef CMD_QUEUE_STATS_EN
  logic [15:0] swap_cnt_q, swap_cnt_d;
  logic [5:0]  drop_cnt_q, drop_cnt_d;

  // Swap counter wraps; drop counter saturates
  always_comb begin
    swap_cnt_d = swap_cnt_q + 16'(issue_swap_s);
    if (drop_s && drop_cnt_q != 6'd63) begin
      drop_cnt_d = drop_cnt_q + 6'd1;
    end else begin
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Statistics registers
  always_ff @(posedge clk) begin
    if (reset) begin
      swap_cnt_q <= 16'd0;
      drop_cnt_q <= 6'd0;
    end else begin
      swap_cnt_q <= swap_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

  // Status word, overflow flag and registered read data
  always_comb begin
    status_s = 32'h0;
    status_s[STAT_FILL_MSB:0] = fifo_count_s;
    status_s[STAT_OVF_BIT]    = ovf_q;
    status_s[STAT_SWAP_BIT]   = (state_q == ST_WAIT_VBLANK);
`ifdef CMD_QUEUE_STATS_EN
    status_s[STAT_SWAPCNT_MSB:STAT_SWAPCNT_LSB] = swap_cnt_q;
    status_s[STAT_DROP_MSB:STAT_DROP_LSB]       = drop_cnt_q;
`endif
    // A drop in the same cycle as a read keeps overflow set
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (avs_read) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
    if (avs_read) begin
      readdata_d = status_s;
    end else begin
      readdata_d = readdata_q;
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= 32'h0;
      readdata_q  <= 32'h0;
      ovf_q       <= 1'b0;
      swap_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      readdata_q  <= readdata_d;
      ovf_q       <= ovf_d;
      swap_done_q <= swap_done_d;
    end
  end

  assign cmd_out      = cmd_q;
  assign avs_readdata = readdata_q;

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Directed testbench for sprite_cmd_queue (DEPTH=16, VBLANK_LINE=480).
module tb_sprite_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic [9:0]  vcount;
  logic [31:0] cmd_out;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [31:0] CMD_A  = 32'h0802_4005;
  localparam logic [31:0] CMD_B  = 32'h0802_4007;
  localparam logic [31:0] CMD_SW = 32'h001E_2000;
  localparam logic [31:0] CMD_S2 = 32'h001E_2002;
  localparam logic [31:0] CMD_NP = 32'h0800_0005;
  localparam logic [31:0] CMD_X  = 32'h0802_40AA;

  always #5 clk = ~clk;

  sprite_cmd_queue #(.DEPTH(16), .VBLANK_LINE(480)) dut (
    .clk           (clk),
    .reset         (reset),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .vcount        (vcount),
    .cmd_out       (cmd_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic wr(input logic [31:0] w);
    avs_write     = 1'b1;
    avs_writedata = w;
    tick;
    avs_write     = 1'b0;
  endtask

  task automatic rd(output logic [31:0] v);
    avs_read = 1'b1;
    tick;
    avs_read = 1'b0;
    v = avs_readdata;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] st;
    logic [31:0] exp_stat;
    int nz;
    reset = 1'b1; avs_write = 1'b0; avs_writedata = 32'h0;
    avs_read = 1'b0; vcount = 10'd100;
    do_reset;
    check("rst_cmd_out", cmd_out, 32'h0);
    check("rst_readdata", avs_readdata, 32'h0);

    // Single update: visible two cycles after the write, for one cycle
    wr(CMD_A);
    check("lat_n1", cmd_out, 32'h0);
    tick; check("lat_n2", cmd_out, CMD_A);
    tick; check("lat_n3", cmd_out, 32'h0);

    // NOP is swallowed, following update appears one cycle later
    wr(CMD_NP);
    check("nop_n1", cmd_out, 32'h0);
    wr(CMD_B);
    check("nop_n2", cmd_out, 32'h0);
    tick; check("nop_upd", cmd_out, CMD_B);
    tick; check("nop_idle", cmd_out, 32'h0);

    // Update A, swap, update B: swap held until vblank, B blocked behind it
    wr(CMD_A);  check("ord_n1", cmd_out, 32'h0);
    wr(CMD_SW); check("ord_a", cmd_out, CMD_A);
    wr(CMD_B);  check("ord_hold", cmd_out, 32'h0);
    tick;       check("ord_hold2", cmd_out, 32'h0);
    rd(st);
    check("ord_pend", {31'b0, st[9]}, 32'd1);
    check("ord_fill", {25'b0, st[6:0]}, 32'd2);
    check("ord_hold3", cmd_out, 32'h0);
    vcount = 10'd480;
    tick; check("ord_swap", cmd_out, CMD_SW);
    tick; check("ord_b", cmd_out, CMD_B);
    tick; check("ord_idle", cmd_out, 32'h0);
    rd(st);
    check("ord_nopend", {31'b0, st[9]}, 32'd0);

    // Two swaps: one per vblank entry
    vcount = 10'd479;
    do_reset;
    wr(CMD_SW);
    wr(CMD_S2);
    nz = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      if (cmd_out != 32'h0) nz++;
    end
    check("fr_pre", 32'(nz), 32'd0);
    vcount = 10'd480;
    tick; check("fr_swap1", cmd_out, CMD_SW);
    nz = 0;
    for (int v = 481; v <= 524; v++) begin
      vcount = 10'(v);
      tick;
      if (cmd_out != 32'h0) nz++;
    end
    for (int v = 0; v <= 479; v++) begin
      vcount = 10'(v);
      tick;
      if (cmd_out != 32'h0) nz++;
    end
    check("fr_between", 32'(nz), 32'd0);
    vcount = 10'd480;
    tick; check("fr_swap2", cmd_out, CMD_S2);
    tick; check("fr_idle", cmd_out, 32'h0);
    rd(st);
`ifdef CMD_QUEUE_STATS_EN
    exp_stat = 32'd2;
    check("fr_swapcnt", {16'b0, st[31:16]}, exp_stat);
`else
    exp_stat = 32'd0;
    check("fr_hibits", {10'b0, st[31:10]}, exp_stat);
`endif

    // Fill while blocked by a swap: 17th word is dropped
    vcount = 10'd100;
    do_reset;
    wr(CMD_SW);
    for (int i = 1; i <= 16; i++) wr(32'h0802_4000 + 32'(i));
    rd(st);
    check("ovf_fill", {25'b0, st[6:0]}, 32'd16);
    check("ovf_set", {31'b0, st[8]}, 32'd1);
    rd(st);
    check("ovf_clr", {31'b0, st[8]}, 32'd0);
`ifdef CMD_QUEUE_STATS_EN
    exp_stat = 32'd1;
`else
    exp_stat = 32'd0;
`endif
    check("ovf_dropcnt", {26'b0, st[15:10]}, exp_stat);

    // Simultaneous write and pop at full
    vcount        = 10'd480;
    avs_write     = 1'b1;
    avs_writedata = CMD_X;
    tick;
    avs_write = 1'b0;
    check("full_swap", cmd_out, CMD_SW);
    avs_read = 1'b1;
    tick;
    avs_read = 1'b0;
    check("full_fill", {25'b0, avs_readdata[6:0]}, 32'd16);
    check("full_noovf", {31'b0, avs_readdata[8]}, 32'd0);
    check("full_d1", cmd_out, 32'h0802_4001);
    for (int i = 2; i <= 15; i++) begin
      tick;
      check("full_order", cmd_out, 32'h0802_4000 + 32'(i));
    end
    tick; check("full_x", cmd_out, CMD_X);
    tick; check("full_idle", cmd_out, 32'h0);

    // Reset while waiting for vblank discards the swap; write during reset ignored
    vcount = 10'd100;
    do_reset;
    wr(CMD_SW);
    tick;
    tick;
    rd(st);
    check("rw_pend", {31'b0, st[9]}, 32'd1);
    reset         = 1'b1;
    avs_write     = 1'b1;
    avs_writedata = CMD_A;
    tick;
    reset     = 1'b0;
    avs_write = 1'b0;
    vcount    = 10'd480;
    nz = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (cmd_out != 32'h0) nz++;
    end
    check("rw_noswap", 32'(nz), 32'd0);
    rd(st);
    check("rw_fill", {25'b0, st[6:0]}, 32'd0);
    check("rw_nopend", {31'b0, st[9]}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
